ex_divmod_unit: RTL and testbench



---
 rtl/ex_divmod_unit.sv | 208 ++++++++++++++++++++
 tb/tb_ex_divmod_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_divmod_unit.sv
// ---------------------------------------------------------------------------
// ex_divmod_unit
//   Multi-cycle signed divide / modulo unit for the EX stage. Radix-2
//   restoring division on operand magnitudes (one quotient bit per cycle),
//   followed by a sign fix-up step. Division truncates toward zero; the
//   remainder takes the sign of the dividend.
//
// Ports
//   clk        pipeline clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request a new operation (sampled only in IDLE)
//   is_mod     0 = return quotient, 1 = return remainder (captured with start)
//   dividend   operand A, two's complement
//   divisor    operand B, two's complement
//   flush      kill the operation in flight (CALC/FIX) or a start in IDLE
//   busy       high whenever the unit is not IDLE
//   stall      pipeline hold request (IDLE&start&~flush | CALC | FIX)
//   done       one-cycle completion pulse; result valid in that cycle
//   result     quotient or remainder, chosen by the captured is_mod
//   quotient   signed quotient of the last completed operation
//   remainder  signed remainder of the last completed operation
// ---------------------------------------------------------------------------
module ex_divmod_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_mod,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Two's complement negation in WIDTH bits.
    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Magnitude as an unsigned WIDTH-bit value; MIN_INT maps onto itself,
    // which is exactly 2^(WIDTH-1) when read as unsigned.
    function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg_f(v) : v;
    endfunction

    state_e           state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] dvd_q,     dvd_d;      // |dividend| shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q,     dvs_d;      // |divisor|
    logic [WIDTH-1:0] rem_q,     rem_d;      // partial remainder (always < |divisor|)
    logic             neg_quo_q, neg_quo_d;  // operand signs differ
    logic             neg_rem_q, neg_rem_d;  // dividend was negative
    logic             is_mod_q,  is_mod_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic [WIDTH-1:0] quot_q,    quot_d;
    logic [WIDTH-1:0] rmdr_q,    rmdr_d;

    logic             accept_s;
    logic             div_zero_s;
    logic             overflow_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   trial_s;
    logic             step_ok_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    assign accept_s   = (state_q == ST_IDLE) && start && !flush;
    assign div_zero_s = (divisor == ZERO);
    assign overflow_s = (dividend == MIN_INT) && (divisor == ALL_ONES);

    // One restoring step: the shifted partial remainder carries an extra bit
    // so the trial subtraction's sign is its MSB.
    assign rem_shift_s = {rem_q, dvd_q[WIDTH-1]};
    assign trial_s     = rem_shift_s - {1'b0, dvs_q};
    assign step_ok_s   = ~trial_s[WIDTH];

    assign quo_fix_s = neg_quo_q ? neg_f(dvd_q) : dvd_q;
    assign rem_fix_s = neg_rem_q ? neg_f(rem_q) : rem_q;

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign stall     = accept_s || (state_q == ST_CALC) || (state_q == ST_FIX);
    assign result    = result_q;
    assign quotient  = quot_q;
    assign remainder = rmdr_q;

    // Next-state and datapath update for the divide sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_mod_d  = is_mod_q;
        result_d  = result_q;
        quot_d    = quot_q;
        rmdr_d    = rmdr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    is_mod_d  = is_mod;
                    dvd_d     = abs_f(dividend);
                    dvs_d     = abs_f(divisor);
                    rem_d     = ZERO;
                    cnt_d     = {CW{1'b0}};
                    neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d = dividend[WIDTH-1];
                    if (div_zero_s) begin
                        quot_d   = ALL_ONES;
                        rmdr_d   = dividend;
                        result_d = is_mod ? dividend : ALL_ONES;
                        state_d  = ST_DONE;
                    end else if (overflow_s) begin
                        quot_d   = MIN_INT;
                        rmdr_d   = ZERO;
                        result_d = is_mod ? ZERO : MIN_INT;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = step_ok_s ? trial_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], step_ok_s};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    quot_d   = quo_fix_s;
                    rmdr_d   = rem_fix_s;
                    result_d = is_mod_q ? rem_fix_s : quo_fix_s;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            dvd_q     <= ZERO;
            dvs_q     <= ZERO;
            rem_q     <= ZERO;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_mod_q  <= 1'b0;
            result_q  <= ZERO;
            quot_q    <= ZERO;
            rmdr_q    <= ZERO;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_mod_q  <= is_mod_d;
            result_q  <= result_d;
            quot_q    <= quot_d;
            rmdr_q    <= rmdr_d;
        end
    end

endmodule

// File: tb/tb_ex_divmod_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_divmod_unit
//   Scoreboard bench for ex_divmod_unit (WIDTH=32). The driver pushes the
//   expected quotient/remainder/result and completion cycle when it issues
//   an operation; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_ex_divmod_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_mod = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy, stall, done;
    logic [31:0] result, quotient, remainder;

    ex_divmod_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_mod(is_mod),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .busy(busy), .stall(stall), .done(done),
        .result(result), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int fails  = 0;
    logic [31:0] last_q = 32'd0, last_r = 32'd0, last_res = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] ident;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: actual done=1 required no pulse (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("result", result, e.m ? e.r : e.q);
                ident = quotient * e.b + remainder;
                chk("identity", ident, e.a);
                last_q   = e.q;
                last_r   = e.r;
                last_res = e.m ? e.r : e.q;
            end
        end
    end

    // Drive start for one cycle in IDLE; optionally record the expectation.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic m,
                         input logic [31:0] q, input logic [31:0] r, input bit push);
        exp_t e;
        bit   special;
        @(posedge clk);
        #1;
        start = 1'b1; dividend = a; divisor = b; is_mod = m;
        special = (b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (push) begin
            e.a = a; e.b = b; e.m = m; e.q = q; e.r = r;
            e.cyc = cyc + (special ? 1 : 34);
            sb.push_back(e);
        end
        #1;
        chk("stall_on_start", {31'd0, stall}, {31'd0, ~flush});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL timeout_%s: actual no done within 80 cycles required done pulse", name);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                          input logic [31:0] q, input logic [31:0] r);
        issue(a, b, m, q, r, 1'b1);
        wait_done("op");
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint la, lb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la % lb;
            q = lq[31:0];
            r = lr[31:0];
        end
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs [0:16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool [0:6];
        logic [31:0] ra, rb, rq, rr;
        logic        rm;

        vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,  1'b0, 32'hFFFFFFF2,  32'd2};
        vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 32'd14,        32'hFFFFFFFE};
        vecs[4]  = '{32'd0,         32'd5,         1'b0, 32'd0,         32'd0};
        vecs[5]  = '{32'd7,         32'd1,         1'b0, 32'd7,         32'd0};
        vecs[6]  = '{32'd7,         32'hFFFFFFFF,  1'b0, 32'hFFFFFFF9,  32'd0};
        vecs[7]  = '{32'h7FFFFFFF,  32'd2,         1'b1, 32'h3FFFFFFF,  32'd1};
        vecs[8]  = '{32'h80000000,  32'd2,         1'b0, 32'hC0000000,  32'd0};
        vecs[9]  = '{32'h80000000,  32'h7FFFFFFF,  1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF};
        vecs[10] = '{32'h7FFFFFFF,  32'h80000000,  1'b1, 32'd0,         32'h7FFFFFFF};
        vecs[11] = '{32'h80000000,  32'd1,         1'b0, 32'h80000000,  32'd0};
        vecs[12] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'h80000000,  32'd0};
        vecs[13] = '{32'h12345678,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h12345678};
        vecs[14] = '{32'd3,         32'd5,         1'b1, 32'd0,         32'd3};
        vecs[15] = '{32'hFFFFFFFF,  32'd2,         1'b1, 32'd0,         32'hFFFFFFFF};
        vecs[16] = '{32'd0,         32'd0,         1'b1, 32'hFFFFFFFF,  32'd0};

        pool[0] = 32'd0;         pool[1] = 32'd1;        pool[2] = 32'hFFFFFFFF;
        pool[3] = 32'h80000000;  pool[4] = 32'h7FFFFFFF; pool[5] = 32'd7;
        pool[6] = 32'hFFFFFFF9;

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        rst_n = 1'b1;

        // 100 / 7 with the stall profile: high cycles 0..33, low in 34.
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            chk("stall_busy_window", {31'd0, stall}, 32'd1);
        end
        @(negedge clk);
        chk("stall_in_done", {31'd0, stall}, 32'd0);
        chk("done_at_34", {31'd0, done}, 32'd1);

        // Directed vectors.
        for (int i = 1; i <= 16; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].q, vecs[i].r);
        end

        // start together with flush in IDLE is ignored.
        flush = 1'b1;
        issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);
        flush = 1'b0;
        chk("flush_start_ignored", {31'd0, busy}, 32'd0);

        // Flush mid-CALC: no done, outputs held; restart in cycle 12.
        issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_idle", {31'd0, busy}, 32'd0);
        chk("flush_hold_result", result, last_res);
        chk("flush_hold_quotient", quotient, last_q);
        chk("flush_hold_remainder", remainder, last_r);
        run_op(32'd9, 32'd2, 1'b0, 32'd4, 32'd1);

        // start re-pulsed in CALC (cycle 5) and DONE (cycle 34) is ignored.
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b1);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; dividend = 32'd7; divisor = 32'd3; is_mod = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (28) @(posedge clk);
        #1 start = 1'b1;
        #1 chk("stall_low_in_done", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-CALC.
        issue(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_quotient", quotient, 32'd0);
        chk("arst_remainder", remainder, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Random signed pairs biased toward the corner values.
        for (int i = 0; i < 30; i++) begin
            ra = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 6)] : $urandom;
            rb = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 6)] : $urandom;
            rm = 1'($urandom_range(0, 1));
            model(ra, rb, rq, rr);
            run_op(ra, rb, rm, rq, rr);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
